game_sequencer: RTL and testbench



---
 rtl/game_pkg.sv | 44 ++++
 rtl/line_merge.sv | 55 +++++
 rtl/game_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_game_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the 2048 board sequencer.
//   cell_t     4-bit tile exponent (0 = empty, k = tile 2^k)
//   dir_t      move direction encoding
//   state_t    sequencer FSM states
//   LINE_IDX   (dir, line, position) -> cell index lookup, position 0 is the
//              edge the tiles move toward
//   LFSR_TAPS  Fibonacci taps 16,14,13,11
package game_pkg;

  typedef logic [3:0] cell_t;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;

  typedef enum logic [2:0] {INIT, IDLE, SLIDE, SPAWN, CHECK} state_t;

  localparam cell_t       EMPTY     = 4'd0;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Packed table: entry {dir,line,pos} holds a 4-bit cell index.
  function automatic logic [255:0] build_line_idx();
    logic [255:0] t;
    int           idx;
    t = '0;
    for (int d = 0; d < 4; d++)
      for (int l = 0; l < 4; l++)
        for (int p = 0; p < 4; p++) begin
          case (d)
            0:       idx = l + 4 * p;
            1:       idx = l + 4 * (3 - p);
            2:       idx = 4 * l + p;
            default: idx = 4 * l + 3 - p;
          endcase
          t[(d * 16 + l * 4 + p) * 4 +: 4] = idx[3:0];
        end
    return t;
  endfunction

  localparam logic [255:0] LINE_IDX = build_line_idx();

  function automatic cell_t line_idx(dir_t d, logic [1:0] l, logic [1:0] p);
    return LINE_IDX[{d, l, p, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/line_merge.sv
// line_merge: combinational slide/merge of one 4-cell line toward element 0.
//   cells_in   4 exponents, element 0 at the movement edge
//   cells_out  compacted and merged line
//   score_inc  sum of 2^(new exponent) over merges (saturates at 16'hFFFF)
//   changed    cells_out differs from cells_in
module line_merge
  import game_pkg::*;
(
  input  cell_t [3:0] cells_in,
  output cell_t [3:0] cells_out,
  output logic [15:0] score_inc,
  output logic        changed
);

  // comp[4] stays empty so the pair test at element 3 needs no guard.
  cell_t [4:0] comp;
  logic  [2:0] k;
  logic  [2:0] j;
  logic        skip;
  logic [16:0] inc;

  always_comb begin
    comp = '0;
    k    = '0;
    for (int i = 0; i < 4; i++)
      if (cells_in[i] != EMPTY) begin
        comp[k] = cells_in[i];
        k       = k + 3'd1;
      end

    // skip marks the second cell of a merged pair so it cannot merge again.
    cells_out = '0;
    inc       = '0;
    skip      = 1'b0;
    j         = '0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[i] != EMPTY && comp[i] == comp[i+1] && comp[i] != 4'hF) begin
        cells_out[j[1:0]] = comp[i] + 4'd1;
        inc               = inc + (17'd1 << (comp[i] + 4'd1));
        skip              = 1'b1;
        j                 = j + 3'd1;
      end else begin
        cells_out[j[1:0]] = comp[i];
        j                 = j + 3'd1;
      end
    end
  end

  // Two exponent-15 merges would be 2^16; clamp rather than wrap.
  assign score_inc = inc[16] ? 16'hFFFF : inc[15:0];
  assign changed   = (cells_out != cells_in);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: multi-cycle 2048 move controller.
//   clk, rst          clock, synchronous active-low reset
//   move_valid/dir    direction command (0 up, 1 down, 2 left, 3 right)
//   move_ready        command accepted when valid & ready
//   undo_req          one-cycle undo pulse (GAME_SEQUENCER_UNDO_EN only)
//   board             cell i at [4i+:4], row i/4, col i%4
//   score             saturating running score
//   move_done, moved  completion pulse and "board changed" flag
//   won, game_over    sticky status
// Build option: define GAME_SEQUENCER_UNDO_EN for a one-level undo snapshot.
module game_sequencer
  import game_pkg::*;
#(
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          WIN_EXP = 11,
  parameter int          SCORE_W = 21
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               move_valid,
  input  logic [1:0]         move_dir,
  output logic               move_ready,
  input  logic               undo_req,
  output logic [63:0]        board,
  output logic [SCORE_W-1:0] score,
  output logic               move_done,
  output logic               moved,
  output logic               won,
  output logic               game_over
);

  localparam cell_t WIN_CELL = cell_t'(WIN_EXP);

  state_t             state_q, state_n;
  dir_t               dir_q, dir_n;
  logic [1:0]         line_q, line_n;
  logic               macc_q, macc_n;
  logic [3:0]         probe_q, probe_n;
  logic [3:0]         pcnt_q, pcnt_n;
  logic               from_move_q, from_move_n;
  logic               init_pend_q, init_pend_n;
  cell_t [15:0]       board_q, board_n;
  logic [SCORE_W-1:0] score_q, score_n;
  logic               won_q, won_n;
  logic               go_q, go_n;
  logic               done_q, done_n;
  logic               moved_q, moved_n;
  logic [15:0]        lfsr_q;

`ifdef GAME_SEQUENCER_UNDO_EN
  cell_t [15:0]       snap_board_q, snap_board_n;
  logic [SCORE_W-1:0] snap_score_q, snap_score_n;
  logic               snap_vld_q, snap_vld_n;
`else
  logic               unused_undo;
  assign unused_undo = undo_req;
`endif

  // Shared line datapath: gather the active line in movement order.
  cell_t [3:0] line_in, line_out;
  logic [15:0] line_inc;
  logic        line_chg;

  always_comb begin
    line_in = '0;
    for (int p = 0; p < 4; p++)
      line_in[p] = board_q[line_idx(dir_q, line_q, 2'(p))];
  end

  line_merge u_merge (
    .cells_in  (line_in),
    .cells_out (line_out),
    .score_inc (line_inc),
    .changed   (line_chg)
  );

  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;
  assign score_sum = {1'b0, score_q} + {{(SCORE_W-15){1'b0}}, line_inc};
  assign score_sat = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  // Board status for CHECK.
  logic any_win, any_move;
  always_comb begin
    any_win  = 1'b0;
    any_move = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (board_q[i] >= WIN_CELL) any_win  = 1'b1;
      if (board_q[i] == EMPTY)    any_move = 1'b1;
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (board_q[r*4+c] == board_q[r*4+c+1] && board_q[r*4+c] != 4'hF) any_move = 1'b1;
    for (int i = 0; i < 12; i++)
      if (board_q[i] == board_q[i+4] && board_q[i] != 4'hF) any_move = 1'b1;
  end

  always_comb begin
    state_n     = state_q;
    dir_n       = dir_q;
    line_n      = line_q;
    macc_n      = macc_q;
    probe_n     = probe_q;
    pcnt_n      = pcnt_q;
    from_move_n = from_move_q;
    init_pend_n = init_pend_q;
    board_n     = board_q;
    score_n     = score_q;
    won_n       = won_q;
    go_n        = go_q;
    done_n      = 1'b0;
    moved_n     = 1'b0;
    move_ready  = 1'b0;
`ifdef GAME_SEQUENCER_UNDO_EN
    snap_board_n = snap_board_q;
    snap_score_n = snap_score_q;
    snap_vld_n   = snap_vld_q;
`endif

    case (state_q)
      INIT: begin
        state_n     = SPAWN;
        probe_n     = lfsr_q[7:4];
        pcnt_n      = '0;
        from_move_n = 1'b0;
        init_pend_n = 1'b1;
      end

      IDLE: begin
`ifdef GAME_SEQUENCER_UNDO_EN
        // Undo wins over a simultaneous command by dropping ready.
        move_ready = !go_q && !undo_req;
        if (undo_req && snap_vld_q) begin
          board_n    = snap_board_q;
          score_n    = snap_score_q;
          go_n       = 1'b0;
          snap_vld_n = 1'b0;
        end
`else
        move_ready = !go_q;
`endif
        if (move_valid && move_ready) begin
          dir_n   = dir_t'(move_dir);
          line_n  = '0;
          macc_n  = 1'b0;
          state_n = SLIDE;
`ifdef GAME_SEQUENCER_UNDO_EN
          snap_board_n = board_q;
          snap_score_n = score_q;
          snap_vld_n   = 1'b1;
`endif
        end
      end

      SLIDE: begin
        for (int p = 0; p < 4; p++)
          board_n[line_idx(dir_q, line_q, 2'(p))] = line_out[p];
        score_n = score_sat;
        macc_n  = macc_q | line_chg;
        line_n  = line_q + 2'd1;
        if (line_q == 2'd3) begin
          if (macc_q | line_chg) begin
            state_n     = SPAWN;
            probe_n     = lfsr_q[7:4];
            pcnt_n      = '0;
            from_move_n = 1'b1;
          end else begin
            done_n  = 1'b1;
            state_n = IDLE;
          end
        end
      end

      SPAWN: begin
        if (board_q[probe_q] == EMPTY) begin
          board_n[probe_q] = (lfsr_q[3:0] == 4'd0) ? 4'd2 : 4'd1;
          state_n          = CHECK;
        end else begin
          probe_n = probe_q + 4'd1;
          pcnt_n  = pcnt_q + 4'd1;
          if (pcnt_q == 4'd15) state_n = CHECK;
        end
      end

      CHECK: begin
        won_n = won_q | any_win;
        go_n  = !any_move;
        if (from_move_q) begin
          done_n  = 1'b1;
          moved_n = 1'b1;
          state_n = IDLE;
        end else if (init_pend_q) begin
          // Second opening tile.
          init_pend_n = 1'b0;
          state_n     = SPAWN;
          probe_n     = lfsr_q[7:4];
          pcnt_n      = '0;
        end else begin
          state_n = IDLE;
        end
      end

      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= INIT;
      dir_q       <= UP;
      line_q      <= '0;
      macc_q      <= 1'b0;
      probe_q     <= '0;
      pcnt_q      <= '0;
      from_move_q <= 1'b0;
      init_pend_q <= 1'b0;
      board_q     <= '0;
      score_q     <= '0;
      won_q       <= 1'b0;
      go_q        <= 1'b0;
      done_q      <= 1'b0;
      moved_q     <= 1'b0;
      lfsr_q      <= SEED;
`ifdef GAME_SEQUENCER_UNDO_EN
      snap_board_q <= '0;
      snap_score_q <= '0;
      snap_vld_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_n;
      dir_q       <= dir_n;
      line_q      <= line_n;
      macc_q      <= macc_n;
      probe_q     <= probe_n;
      pcnt_q      <= pcnt_n;
      from_move_q <= from_move_n;
      init_pend_q <= init_pend_n;
      board_q     <= board_n;
      score_q     <= score_n;
      won_q       <= won_n;
      go_q        <= go_n;
      done_q      <= done_n;
      moved_q     <= moved_n;
      lfsr_q      <= {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
`ifdef GAME_SEQUENCER_UNDO_EN
      snap_board_q <= snap_board_n;
      snap_score_q <= snap_score_n;
      snap_vld_q   <= snap_vld_n;
`endif
    end
  end

  assign board     = board_q;
  assign score     = score_q;
  assign move_done = done_q;
  assign moved     = moved_q;
  assign won       = won_q;
  assign game_over = go_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed bench for game_sequencer. Boards are loaded by
// hierarchical write while the sequencer sits in IDLE; spawned tiles are
// checked by position set and exponent range since the LFSR picks them.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        move_valid = 1'b0;
  logic [1:0]  move_dir = 2'd0;
  logic        undo_req = 1'b0;
  logic        move_ready;
  logic [63:0] board;
  logic [20:0] score;
  logic        move_done, moved, won, game_over;

  int n_vec = 0;
  int n_bad = 0;

  game_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .move_valid (move_valid),
    .move_dir   (move_dir),
    .move_ready (move_ready),
    .undo_req   (undo_req),
    .board      (board),
    .score      (score),
    .move_done  (move_done),
    .moved      (moved),
    .won        (won),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] row(input logic [3:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic int nz(input logic [63:0] b);
    int n = 0;
    for (int i = 0; i < 16; i++) if (b[4*i+:4] != 4'd0) n++;
    return n;
  endfunction

  function automatic logic small_ok(input logic [63:0] b);
    logic ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (b[4*i+:4] > 4'd2) ok = 1'b0;
    return ok;
  endfunction

  // Exactly one of the two cells holds a fresh 1 or 2.
  function automatic logic spawn_one(input logic [3:0] a, input logic [3:0] b);
    return ((a == 4'd0) != (b == 4'd0)) && (((a | b) == 4'd1) || ((a | b) == 4'd2));
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!move_ready && n < 200) begin @(negedge clk); n++; end
    chk(tag, move_ready, 1);
  endtask

  task automatic poke(input logic [63:0] b, input logic [20:0] s);
    dut.board_q = b;
    dut.score_q = s;
  endtask

  // Entered at a negedge; returns at the negedge where move_done is seen.
  // lat = cycles from the handshake edge to the move_done edge.
  task automatic send(input logic [1:0] d, output int lat, output logic mv);
    int n = 0;
    move_dir   = d;
    move_valid = 1'b1;
    while (!move_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    move_valid = 1'b0;
    lat = 0;
    while (!move_done && lat < 40) begin @(negedge clk); lat++; end
    mv = moved;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic        mv;
    logic        seen;
    logic [63:0] b0, b3, b4, b5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_board", board, 0);
    chk("rst_score", score, 0);
    chk("rst_ready", move_ready, 0);
    chk("rst_done", move_done, 0);
    chk("rst_flags", {won, game_over}, 0);
    rst = 1'b1;
    wait_ready("init_ready");
    chk("init_tiles", nz(board), 2);
    chk("init_exp", small_ok(board), 1);
    chk("init_score", score, 0);

    // Row0 [1,1,2,0] left -> [2,2,_,_]; the merged 2 does not merge again,
    // so the increment is 4, and the score saturates at 2^21-1.
    b0 = {row(3,4,3,4), row(4,3,4,3), row(3,4,3,4), row(1,1,2,0)};
    poke(b0, 21'h1FFFFD);
    send(2'd2, lat, mv);
    chk("t2_moved", mv, 1);
    chk("t2_lat", (lat >= 6 && lat <= 21), 1);
    chk("t2_rows", board[63:16], b0[63:16]);
    chk("t2_row0", board[7:0], 8'h22);
    chk("t2_spawn", spawn_one(board[11:8], board[15:12]), 1);
    chk("t2_score_sat", score, 21'h1FFFFF);
    chk("t2_won", won, 0);

    // Already packed left, no equal neighbours, 15-15 pair must not merge.
    b3 = {row(15,15,0,0), row(3,4,5,6), row(3,4,5,0), row(1,2,0,0)};
    poke(b3, 21'd500);
    send(2'd2, lat, mv);
    chk("t3_lat", lat, 4);
    chk("t3_moved", mv, 0);
    chk("t3_board", board, b3);
    chk("t3_score", score, 500);

    // Column 0 [10,10,0,0] up -> 11 at cell 0, won, +2048.
    b5 = {16'h0, 16'h0, row(10,0,0,0), row(10,0,0,0)};
    poke(b5, 21'd0);
    send(2'd0, lat, mv);
    chk("t5_moved", mv, 1);
    chk("t5_cell0", board[3:0], 4'd11);
    chk("t5_tiles", nz(board), 2);
    chk("t5_won", won, 1);
    chk("t5_score", score, 2048);
    chk("t5_go", game_over, 0);

    // Nearly full board; right fills cell 12 with a tile that cannot merge.
    b4 = {row(5,6,5,0), row(3,4,3,4), row(4,3,4,3), row(3,4,3,4)};
    poke(b4, 21'd0);
    send(2'd3, lat, mv);
    chk("t4_moved", mv, 1);
    chk("t4_rows", board[47:0], b4[47:0]);
    chk("t4_row3", board[63:52], 12'h565);
    chk("t4_spawn", (board[51:48] == 4'd1 || board[51:48] == 4'd2), 1);
    chk("t4_go", game_over, 1);
    chk("t4_ready", move_ready, 0);
    chk("t4_won_sticky", won, 1);
    move_dir = 2'd2; move_valid = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (move_done || move_ready) seen = 1'b1;
    end
    move_valid = 1'b0;
    chk("t4_blocked", seen, 0);
    chk("t4_board_held", board[63:52], 12'h565);

`ifdef GAME_SEQUENCER_UNDO_EN
    // Undo restores the pre-move board/score and clears game_over.
    undo_req = 1'b1; @(negedge clk); undo_req = 1'b0;
    chk("undo_board", board, b4);
    chk("undo_score", score, 0);
    chk("undo_go", game_over, 0);
    chk("undo_ready", move_ready, 1);
    chk("undo_won", won, 1);
    undo_req = 1'b1; @(negedge clk); undo_req = 1'b0;
    chk("undo2_board", board, b4);
`endif

    // Reset during SLIDE line 2 aborts the move without move_done.
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    wait_ready("rst2_ready0");
    poke(b0, 21'd100);
    move_dir = 2'd2; move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_score_pre", score, 104);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_board", board, 0);
    chk("mid_score", score, 0);
    chk("mid_done", move_done, 0);
    chk("mid_won", won, 0);
    rst = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 200 && !move_ready; n++) begin
      @(negedge clk);
      if (move_done) seen = 1'b1;
    end
    chk("mid_nodone", seen, 0);
    chk("mid_ready", move_ready, 1);
    chk("mid_tiles", nz(board), 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
